// File: rtl/grf_wb_arbiter_pkg.sv
// Shared constants and types for the register-file write-port arbiter.
package grf_wb_arbiter_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned REG_AW   = 5;
  localparam int unsigned NUM_REGS = 32;
  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [REG_AW-1:0] wt;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] pc;
  } wb_entry_t;

endpackage

// File: rtl/grf_wb_arbiter_wb_fifo.sv
// Small FIFO of pending MDU writebacks with an any-entry destination match.
module wb_fifo
  import grf_wb_arbiter_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  wb_entry_t         push_data_i,
  input  logic              pop_i,
  input  logic [REG_AW-1:0] query_i,
  output logic              full_o,
  output logic              empty_o,
  output wb_entry_t         head_o,
  output logic              match_o
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);

  wb_entry_t             mem_q [FIFO_DEPTH];
  wb_entry_t             mem_d [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] valid_q, valid_d;
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;

  assign full_o  = &valid_q;
  assign empty_o = ~|valid_q;
  assign head_o  = mem_q[rd_ptr_q];

  always_comb begin
    match_o = 1'b0;
    for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
      if (valid_q[i] && (mem_q[i].wt == query_i)) match_o = 1'b1;
    end
  end

  // Pop clears before push sets; a push never targets the popped slot unless it was free.
  always_comb begin
    mem_d    = mem_q;
    valid_d  = valid_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (pop_i) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + PtrW'(1);
    end
    if (push_i) begin
      mem_d[wr_ptr_q]   = push_data_i;
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d          = wr_ptr_q + PtrW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= mem_d[i];
      valid_q  <= valid_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/grf_wb_arbiter.sv
// Register-file write-port arbiter: WB stage vs buffered MDU results, plus pending scoreboard.
module grf_wb_arbiter
  import grf_wb_arbiter_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = 2,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pipe_we,
  input  logic [REG_AW-1:0] pipe_wt,
  input  logic [DATA_W-1:0] pipe_wdata,
  input  logic [DATA_W-1:0] pipe_pc,
  output logic              pipe_stall,
  input  logic              mdu_valid,
  output logic              mdu_ready,
  input  logic [REG_AW-1:0] mdu_wt,
  input  logic [DATA_W-1:0] mdu_wdata,
  input  logic [DATA_W-1:0] mdu_pc,
  input  logic              iss_valid,
  input  logic [REG_AW-1:0] iss_wt,
  input  logic [REG_AW-1:0] rd1,
  input  logic [REG_AW-1:0] rd2,
  output logic              busy1,
  output logic              busy2,
  output logic              grf_we,
  output logic [REG_AW-1:0] grf_wt,
  output logic [DATA_W-1:0] grf_wdata,
  output logic [DATA_W-1:0] grf_wpc
);

  logic                full, empty, hit, push, pop, pw;
  wb_entry_t           head;
  logic [CNT_W-1:0]    starve_cnt_q, starve_cnt_d;
  logic [NUM_REGS-1:0] pending_q, pending_d;

  assign mdu_ready = !reset && !full;
  // Writes to $0 are accepted but never buffered.
  assign push      = mdu_valid && mdu_ready && (mdu_wt != REG_ZERO);
  assign pw        = pipe_we && (pipe_wt != REG_ZERO);

  wb_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i      (clk),
    .rst_i      (reset),
    .push_i     (push),
    .push_data_i('{wt: mdu_wt, wdata: mdu_wdata, pc: mdu_pc}),
    .pop_i      (pop),
    .query_i    (pipe_wt),
    .full_o     (full),
    .empty_o    (empty),
    .head_o     (head),
    .match_o    (hit)
  );

  always_comb begin
    pop        = 1'b0;
    pipe_stall = 1'b0;
    grf_we     = 1'b0;
    grf_wt     = REG_ZERO;
    grf_wdata  = '0;
    grf_wpc    = '0;
    if (!reset) begin
      if (empty) begin
        grf_we = pw;
      end else if (!pw) begin
        pop = 1'b1;
      end else if (!hit && (starve_cnt_q < CNT_W'(STARVE_LIMIT))) begin
        grf_we = 1'b1;
      end else begin
        // Older MDU result to the same register, or a starved head, goes first.
        pop        = 1'b1;
        pipe_stall = 1'b1;
      end
      if (pop) begin
        grf_we    = 1'b1;
        grf_wt    = head.wt;
        grf_wdata = head.wdata;
        grf_wpc   = head.pc;
      end else if (grf_we) begin
        grf_wt    = pipe_wt;
        grf_wdata = pipe_wdata;
        grf_wpc   = pipe_pc;
      end
    end
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (pop) begin
      starve_cnt_d = '0;
    end else if (!empty && (starve_cnt_q < CNT_W'(STARVE_LIMIT))) begin
      starve_cnt_d = starve_cnt_q + CNT_W'(1);
    end
  end

  // Set after clear so a same-cycle issue to the popped register keeps it pending.
  always_comb begin
    pending_d = pending_q;
    if (pop) pending_d[head.wt] = 1'b0;
    if (iss_valid && (iss_wt != REG_ZERO)) pending_d[iss_wt] = 1'b1;
  end

  assign busy1 = pending_q[rd1];
  assign busy2 = pending_q[rd2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt_q <= '0;
      pending_q    <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      pending_q    <= pending_d;
    end
  end

endmodule
